sqrt_share_ctrl: RTL and testbench

//  Shares one multi-cycle bitnum sqrt unit between NREQ requesters.

---
 rtl/sqrt_ctrl_pkg.sv | 14 +
 rtl/rr_pick.sv | 33 +++
 rtl/sqrt.sv | 58 +++++
 rtl/sqrt_share_ctrl.sv | 119 +++++++++++
 tb/tb_sqrt_share_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sqrt_ctrl_pkg.sv
// Shared types and helpers for the sqrt sharing controller.
package sqrt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int sqrt_iters(input int w);
    return w >> 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin : pick
    int sum;
    logic [IW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sum     = 0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      sum = int'(ptr) + k;
      if (sum >= N) sum = sum - N;
      idx = IW'(sum);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/sqrt.sv
// Iterative integer square root, one result bit per clock; no reset.
// Dropping go returns it to idle, so any stale run is discarded.
module sqrt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             go,
  input  logic [WIDTH-1:0] din,
  output logic             done,
  output logic [WIDTH-1:0] root
);

  localparam int H  = WIDTH / 2;
  localparam int CW = $clog2(H);

  logic             running;
  logic [CW-1:0]    cnt;
  logic [H:0]       rem;
  logic [H-1:0]     rt;
  logic [WIDTH-1:0] x;
  logic [H+2:0]     rem_sh;
  logic [H+2:0]     trial;
  logic [H+2:0]     diff;

  assign rem_sh = {rem, x[WIDTH-1 -: 2]};
  assign trial  = {1'b0, rt, 2'b01};
  assign diff   = rem_sh - trial;

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (!go) begin
      running <= 1'b0;
    end else if (!running) begin
      running <= 1'b1;
      x       <= din;
      rem     <= '0;
      rt      <= '0;
      cnt     <= '0;
    end else begin
      x   <= x << 2;
      cnt <= cnt + 1'b1;
      if (rem_sh >= trial) begin
        rem <= diff[H:0];
        rt  <= {rt[H-2:0], 1'b1};
      end else begin
        rem <= rem_sh[H:0];
        rt  <= {rt[H-2:0], 1'b0};
      end
      if (cnt == CW'(H - 1)) begin
        running <= 1'b0;
        done    <= 1'b1;
      end
    end
  end

  assign root = {{H{1'b0}}, rt};

endmodule

// File: rtl/sqrt_share_ctrl.sv
// Round-robin sharing of one iterative sqrt unit between NREQ requesters.
//   state | meaning
//   IDLE  | granting the next requester in round-robin order
//   RUN   | sqrt unit running on op_q; waiting for a qualified done
//   RESP  | holding root for the granted requester until it accepts
module sqrt_share_ctrl
  import sqrt_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  busy
);

  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW    = $clog2(WIDTH + 4);
  localparam int ITERS = sqrt_iters(WIDTH);

  state_t           state, state_nx;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    g_q;
  logic [WIDTH-1:0] op_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cyc;

  logic [NREQ-1:0]  pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             sq_go;
  logic             sq_done;
  logic [WIDTH-1:0] sq_out;
  logic             honour;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  sqrt #(.WIDTH(WIDTH)) u_sqrt (
    .clk  (clk),
    .go   (sq_go),
    .din  (op_q),
    .done (sq_done),
    .root (sq_out)
  );

  // The unit is never reset, so done only counts once a full run can have elapsed.
  assign honour = sq_done && (cyc >= CW'(ITERS));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_any) state_nx = RUN;
      RUN:     if (honour) state_nx = RESP;
      RESP:    if (resp_ready[g_q]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_data  = '0;
    sq_go      = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: req_ready = pick_gnt;
      RUN:  sq_go = 1'b1;
      RESP: begin
        resp_valid[g_q] = 1'b1;
        resp_data       = res_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
      g_q    <= '0;
      op_q   <= '0;
      res_q  <= '0;
      cyc    <= '0;
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          op_q <= req_data[pick_idx*WIDTH +: WIDTH];
          g_q  <= pick_idx;
          cyc  <= '0;
        end
        RUN: begin
          if (cyc != {CW{1'b1}}) cyc <= cyc + 1'b1;
          if (honour) res_q <= sq_out;
        end
        RESP: if (resp_ready[g_q]) begin
          rr_ptr <= (g_q == IW'(NREQ - 1)) ? '0 : g_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_share_ctrl.sv
// Scoreboard bench for sqrt_share_ctrl: round-robin grant model plus floor-sqrt reference.
module tb_sqrt_share_ctrl;

  localparam int W = 32;
  localparam int N = 4;
  localparam int H = W / 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   resp_ready = '0;
  logic [W-1:0]   resp_data;
  logic           busy;

  sqrt_share_ctrl #(.WIDTH(W), .NREQ(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           idx;
    logic [W-1:0] root;
    int           t;
  } exp_t;

  // monitor-owned state
  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           mptr = 0;
  int           cyc_n = 0;
  int           acc_cnt[N];
  bit           prev_rv = 0;
  bit           prev_acc = 0;
  bit           prev_rst_low = 0;
  logic [N-1:0] prev_resp_valid = '0;
  logic [W-1:0] prev_resp_data = '0;
  int           tmo_seen = 0;
  bit           end_done = 0;
  int           mg, mp;
  logic [N-1:0] mex;

  // driver-owned state
  logic [W-1:0] pend[N][$];
  int           taken[N];
  int           rr_mode = 0;
  bit           wd_en = 0;
  int           tmo_cnt = 0;
  bit           end_req = 0;

  function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
    longint lo, hi, mid, xv;
    xv = longint'({32'd0, x});
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= xv) lo = mid;
      else hi = mid - 1;
    end
    return W'(lo);
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[k]) return k;
    return -1;
  endfunction

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc_n);
    end
  endtask

  always @(negedge clk) begin
    cyc_n++;
    if (prev_rst_low)
      chk({req_ready, resp_valid, busy, resp_data} == '0, "reset_outputs",
          longint'({req_ready, resp_valid, busy, resp_data}), 0);
    prev_rst_low = !reset;
    if (tmo_cnt != tmo_seen) begin
      tmo_seen = tmo_cnt;
      checks++;
      errors++;
      $display("FAIL wait_bound actual=expired required=done cycle=%0d", cyc_n);
    end
    if (end_req && !end_done) begin
      end_done = 1;
      chk(exp_q.size() == 0, "leftover_expected", exp_q.size(), 0);
    end
    if (!reset) begin
      exp_q.delete();
      mptr = 0;
      prev_rv = 0;
    end else begin
      chk($onehot0(req_ready) && ((req_ready & ~req_valid) == '0), "req_ready_shape",
          longint'(req_ready), longint'(req_valid));
      chk($onehot0(resp_valid), "resp_valid_onehot", longint'(resp_valid), 0);
      chk(!(busy && (|req_ready)), "ready_while_busy", longint'(req_ready), 0);
      if (!busy) begin
        mp  = pick(req_valid, mptr);
        mex = (mp < 0) ? '0 : (N'(1) << mp);
        chk(req_ready == mex, "grant", longint'(req_ready), longint'(mex));
      end
      mg = idx_of(req_ready & req_valid);
      if (mg >= 0) begin
        exp_q.push_back('{idx: mg, root: isqrt(req_data[mg*W +: W]), t: cyc_n});
        acc_cnt[mg]++;
      end
      if (|resp_valid) begin
        mg = idx_of(resp_valid);
        chk(busy, "busy_in_resp", longint'(busy), 1);
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_resp", longint'(resp_valid), 0);
        end else begin
          if (!prev_rv)
            chk((cyc_n - exp_q[0].t) inside {[H+2:H+4]}, "latency",
                cyc_n - exp_q[0].t, H + 3);
          else if (!prev_acc)
            chk(resp_valid == prev_resp_valid && resp_data == prev_resp_data, "resp_hold",
                longint'(resp_data), longint'(prev_resp_data));
          chk(mg == exp_q[0].idx, "resp_port", mg, exp_q[0].idx);
          chk(resp_data == exp_q[0].root, "resp_data", longint'(resp_data),
              longint'(exp_q[0].root));
          prev_acc = resp_ready[mg];
          if (prev_acc) begin
            void'(exp_q.pop_front());
            mptr = (mg + 1) % N;
          end
        end
        prev_rv = 1;
      end else begin
        prev_rv = 0;
      end
      prev_resp_valid = resp_valid;
      prev_resp_data  = resp_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      while (taken[i] < acc_cnt[i]) begin
        if (pend[i].size() > 0) void'(pend[i].pop_front());
        taken[i]++;
      end
      req_valid[i] = (pend[i].size() > 0) && !(wd_en && $urandom_range(0, 3) == 0);
      req_data[i*W +: W] = (pend[i].size() > 0) ? pend[i][0] : W'($urandom);
    end
    case (rr_mode)
      0:       resp_ready = '1;
      1:       resp_ready = N'($urandom);
      default: resp_ready = '0;
    endcase
  endtask

  task automatic push(input int i, input logic [W-1:0] v);
    pend[i].push_back(v);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i].delete();
      taken[i] = acc_cnt[i];
    end
    req_valid = '0;
    repeat (cycles) step();
    reset = 1'b1;
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < N; i++)
      if (pend[i].size() > 0) return 0;
    return (exp_q.size() == 0) && !busy && (req_valid == '0);
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (n < budget && !all_idle()) begin
      step();
      n++;
    end
    if (n >= budget) tmo_cnt++;
  endtask

  task automatic wait_for(input bit want_resp, input int budget);
    int n;
    n = 0;
    while (n < budget && !(want_resp ? (|resp_valid) : busy)) begin
      step();
      n++;
    end
    if (n >= budget) tmo_cnt++;
  endtask

  logic [W-1:0] edge_ops[7];
  logic [W-1:0] rv;
  int           ri;

  initial begin
    for (int i = 0; i < N; i++) begin
      acc_cnt[i] = 0;
      taken[i]   = 0;
    end
    edge_ops = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd15, 32'h4000_0000};

    repeat (3) step();
    reset = 1'b1;

    // single request
    push(0, 32'd144);
    drain(200);

    // all four at once from rr_ptr 0
    do_reset(1);
    push(0, 32'd16); push(1, 32'd25); push(2, 32'd36); push(3, 32'd49);
    drain(400);

    // after serving req2, req3 wins over req1
    do_reset(1);
    push(2, 32'd100);
    drain(200);
    push(1, 32'd9); push(3, 32'd81);
    drain(400);

    // response back-pressure with another request waiting
    rr_mode = 2;
    push(0, 32'd1000);
    wait_for(1'b1, 100);
    push(1, 32'd77);
    repeat (10) step();
    rr_mode = 0;
    drain(400);

    // reset mid-run, then a full-scale operand
    push(2, 32'd12345);
    wait_for(1'b0, 50);
    repeat (5) step();
    do_reset(2);
    push(0, 32'hFFFF_FFFF);
    drain(200);

    for (int k = 0; k < 7; k++) push(k % N, edge_ops[k]);
    drain(1000);

    rr_mode = 1;
    wd_en   = 1;
    for (int n = 0; n < 1000; n++) begin
      ri = $urandom_range(0, N - 1);
      case ($urandom_range(0, 3))
        0:       rv = W'($urandom);
        1:       rv = W'($urandom & 32'hFFFF);
        2: begin
          rv = W'($urandom_range(0, 65535));
          rv = rv * rv - W'($urandom_range(0, 1));
        end
        default: rv = 32'hFFFF_FFFF - W'($urandom_range(0, 300));
      endcase
      push(ri, rv);
      repeat ($urandom_range(0, 20)) step();
    end
    drain(60000);
    wd_en   = 0;
    rr_mode = 0;

    end_req = 1;
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
